cp0_regfile: RTL and testbench

- Parametrised MIPS32 coprocessor-0 register file and access unit for the pipeline's MEM stage.
- Decodes (rd, sel) into an internal register index and flags unmapped encodings.
- Services MFC0 reads with registered latency and MTC0 writes through per-register write masks.
- Runs the Count/Compare timer, records exception entry and ERET, and drives the interrupt request to the exception unit.

---
 rtl/cp0_pkg.sv | 44 ++++
 rtl/cp0_reg_decode.sv | 39 +++
 rtl/cp0_regfile.sv | 223 ++++++++++++++++++++++
 tb/tb_cp0_regfile.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the CP0 register file.
//   - cp0_idx_e   : internal register index produced by cp0_reg_decode
//   - EXC_*       : ExcCode values written into Cause[6:2]
//   - ST_*/CA_*   : Status / Cause bit positions
//   - *_WMASK     : bits that MTC0 is allowed to modify
//   - STATUS_RST  : Status value after reset (BEV=1)
package cp0_pkg;

  typedef enum logic [3:0] {
    CP0_RANDOM,
    CP0_BADVADDR,
    CP0_COUNT,
    CP0_COMPARE,
    CP0_STATUS,
    CP0_CAUSE,
    CP0_EPC,
    CP0_PRID,
    CP0_CONFIG,
    CP0_NONE
  } cp0_idx_e;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_BEV    = 22;

  localparam int CA_BD     = 31;
  localparam int CA_TI     = 30;
  localparam int CA_IP_LO  = 8;
  localparam int CA_EXC_LO = 2;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;

endpackage

// File: rtl/cp0_reg_decode.sv
// cp0_reg_decode: combinational (rd, sel) -> internal register index.
// This is the only place CP0 encodings are decoded; the hazard unit
// instantiates it as well so both agree on what is mapped.
//   rd    : CP0 register number
//   sel   : CP0 select field
//   idx   : decoded index (CP0_NONE when unmapped)
//   valid : 1 when (rd, sel) names an implemented register
// Optional: CP0_RANDOM_EN maps Random at (1,0).
module cp0_reg_decode
  import cp0_pkg::*;
(
  input  logic [4:0] rd,
  input  logic [2:0] sel,
  output cp0_idx_e   idx,
  output logic       valid
);

  always_comb begin
    idx = CP0_NONE;
    if (sel == 3'd0) begin
      case (rd)
`ifdef CP0_RANDOM_EN
        5'd1:    idx = CP0_RANDOM;
`endif
        5'd8:    idx = CP0_BADVADDR;
        5'd9:    idx = CP0_COUNT;
        5'd11:   idx = CP0_COMPARE;
        5'd12:   idx = CP0_STATUS;
        5'd13:   idx = CP0_CAUSE;
        5'd14:   idx = CP0_EPC;
        5'd15:   idx = CP0_PRID;
        5'd16:   idx = CP0_CONFIG;
        default: idx = CP0_NONE;
      endcase
    end
    valid = (idx != CP0_NONE);
  end

endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS32 CP0 register file for the MEM stage.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   rd, sel, rd_en            : MFC0 request; rd_data/rd_valid/rd_err one cycle later
//   wr_en, wr_data            : MTC0 request (uses rd/sel), masked per register
//   exc_req, exc_code, exc_pc,
//   exc_bd, exc_badv_vld,
//   exc_badvaddr              : exception commit
//   eret                      : ERET commit
//   irq_hw                    : level hardware interrupts, sampled into Cause.IP[15:10]
//   epc_out, status_out,
//   cause_out, int_pending    : state to the exception unit
// Optional: CP0_RANDOM_EN enables the Random register at (1,0).
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter int          COUNT_DIV  = 2,
  parameter int          NUM_TLB    = 16,
  parameter logic [31:0] PRID_VAL   = 32'h0001_8000,
  parameter logic [31:0] CONFIG_VAL = 32'h8000_0000,
  parameter int          HW_IRQ     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        rd,
  input  logic [2:0]        sel,
  input  logic              rd_en,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  input  logic              exc_req,
  input  logic [4:0]        exc_code,
  input  logic [31:0]       exc_pc,
  input  logic              exc_bd,
  input  logic              exc_badv_vld,
  input  logic [31:0]       exc_badvaddr,
  input  logic              eret,
  input  logic [HW_IRQ-1:0] irq_hw,
  output logic [31:0]       epc_out,
  output logic [31:0]       status_out,
  output logic [31:0]       cause_out,
  output logic              int_pending
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  // Elaboration-time parameter guards.
  if (COUNT_DIV < 1) begin : g_bad_div
    $error("cp0_regfile: COUNT_DIV must be >= 1");
  end
  if (HW_IRQ < 1 || HW_IRQ > 6) begin : g_bad_irq
    $error("cp0_regfile: HW_IRQ must be 1..6");
  end
  if (NUM_TLB < 1) begin : g_bad_tlb
    $error("cp0_regfile: NUM_TLB must be >= 1");
  end

  cp0_idx_e idx;
  logic     idx_valid;

  cp0_reg_decode u_decode (
    .rd    (rd),
    .sel   (sel),
    .idx   (idx),
    .valid (idx_valid)
  );

  logic [31:0]      status_q,   status_d;
  logic             bd_q,       bd_d;
  logic             ti_q,       ti_d;
  logic [1:0]       ip_sw_q,    ip_sw_d;
  logic [5:0]       ip_hw_q;
  logic [4:0]       exccode_q,  exccode_d;
  logic [31:0]      epc_q,      epc_d;
  logic [31:0]      badv_q,     badv_d;
  logic [31:0]      count_q,    count_d;
  logic [31:0]      compare_q,  compare_d;
  logic [DIV_W-1:0] div_q,      div_d;
  logic [31:0]      rd_data_q,  rd_data_d;
  logic             rd_valid_q;
  logic             rd_err_q;
  logic [31:0]      random_val;
  logic [31:0]      cause_val;
  logic             div_wrap;
  logic             compare_wr;

  // IP7 is shared between hardware line 5 and the timer.
  always_comb begin
    cause_val                = '0;
    cause_val[CA_BD]         = bd_q;
    cause_val[CA_TI]         = ti_q;
    cause_val[15]            = ip_hw_q[5] | ti_q;
    cause_val[14:10]         = ip_hw_q[4:0];
    cause_val[9:8]           = ip_sw_q;
    cause_val[6:2]           = exccode_q;
  end

`ifdef CP0_RANDOM_EN
  localparam int RND_W = (NUM_TLB > 1) ? $clog2(NUM_TLB) : 1;
  logic [RND_W-1:0] random_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                random_q <= RND_W'(NUM_TLB - 1);
    else if (random_q == '0)   random_q <= RND_W'(NUM_TLB - 1);
    else                       random_q <= random_q - 1'b1;
  end

  assign random_val = 32'(random_q);
`else
  assign random_val = '0;
`endif

  always_comb begin
    status_d   = status_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badv_d     = badv_q;
    compare_d  = compare_q;
    compare_wr = 1'b0;

    div_wrap = (div_q == DIV_W'(COUNT_DIV - 1));
    div_d    = div_wrap ? '0 : div_q + 1'b1;
    count_d  = div_wrap ? count_q + 32'd1 : count_q;

    if (exc_req) begin
      status_d[ST_EXL] = 1'b1;
      exccode_d        = exc_code;
      // Nested exceptions keep the original return point.
      if (!status_q[ST_EXL]) begin
        epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
        bd_d  = exc_bd;
      end
      if (exc_badv_vld) badv_d = exc_badvaddr;
    end else if (eret) begin
      status_d[ST_EXL] = 1'b0;
    end else if (wr_en) begin
      case (idx)
        CP0_STATUS:  status_d = (status_q & ~STATUS_WMASK) | (wr_data & STATUS_WMASK);
        CP0_CAUSE:   ip_sw_d = wr_data[9:8];
        CP0_EPC:     epc_d = wr_data;
        CP0_COUNT: begin
          count_d = wr_data;
          div_d   = '0;
        end
        CP0_COMPARE: begin
          compare_d  = wr_data;
          compare_wr = 1'b1;
        end
        default: ;
      endcase
    end

    // TI is edge-triggered on Count reaching Compare; a Compare write acks it.
    ti_d = ti_q;
    if (compare_wr)                                     ti_d = 1'b0;
    else if (count_d != count_q && count_d == compare_q) ti_d = 1'b1;

    // Reads use the pre-update state, so same-cycle writes are not visible.
    rd_data_d = rd_data_q;
    if (rd_en) begin
      case (idx)
        CP0_RANDOM:   rd_data_d = random_val;
        CP0_BADVADDR: rd_data_d = badv_q;
        CP0_COUNT:    rd_data_d = count_q;
        CP0_COMPARE:  rd_data_d = compare_q;
        CP0_STATUS:   rd_data_d = status_q;
        CP0_CAUSE:    rd_data_d = cause_val;
        CP0_EPC:      rd_data_d = epc_q;
        CP0_PRID:     rd_data_d = PRID_VAL;
        CP0_CONFIG:   rd_data_d = CONFIG_VAL;
        default:      rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q   <= STATUS_RST;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      exccode_q  <= '0;
      epc_q      <= '0;
      badv_q     <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      div_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      status_q   <= status_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= 6'(irq_hw);
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badv_q     <= badv_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      div_q      <= div_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      rd_err_q   <= rd_en & ~idx_valid;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_err      = rd_err_q;
  assign epc_out     = epc_q;
  assign status_out  = status_q;
  assign cause_out   = cause_val;
  assign int_pending = status_q[ST_IE] & ~status_q[ST_EXL] &
                       (|(cause_val[15:8] & status_q[15:8]));

endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed self-checking bench for cp0_regfile.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rd = '0;
  logic [2:0]  sel = '0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_err;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        exc_req = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic        exc_bd = 1'b0;
  logic        exc_badv_vld = 1'b0;
  logic [31:0] exc_badvaddr = '0;
  logic        eret = 1'b0;
  logic [5:0]  irq_hw = '0;
  logic [31:0] epc_out;
  logic [31:0] status_out;
  logic [31:0] cause_out;
  logic        int_pending;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cp0_regfile #(
    .COUNT_DIV  (2),
    .NUM_TLB    (16),
    .PRID_VAL   (32'h0001_8000),
    .CONFIG_VAL (32'h8000_0000),
    .HW_IRQ     (6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd           (rd),
    .sel          (sel),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_err       (rd_err),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .exc_req      (exc_req),
    .exc_code     (exc_code),
    .exc_pc       (exc_pc),
    .exc_bd       (exc_bd),
    .exc_badv_vld (exc_badv_vld),
    .exc_badvaddr (exc_badvaddr),
    .eret         (eret),
    .irq_hw       (irq_hw),
    .epc_out      (epc_out),
    .status_out   (status_out),
    .cause_out    (cause_out),
    .int_pending  (int_pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-16s obs=%08h exp=%08h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle MFC0; result checked in the following cycle.
  task automatic do_read(input logic [4:0] r, input logic [2:0] s, output logic [31:0] d,
                         output logic v, output logic e);
    rd = r; sel = s; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    d = rd_data; v = rd_valid; e = rd_err;
  endtask

  task automatic do_write(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
    rd = r; sel = s; wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  logic [31:0] d;
  logic        v, e;

  initial begin
    #12;
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_status",   status_out,    32'h0040_0000);
    chk("rst_cause",    cause_out,     32'h0);
    chk("rst_epc",      epc_out,       32'h0);
    rst_n = 1'b1;

    // Random (1,0): first read is sampled on the first edge after reset.
`ifdef CP0_RANDOM_EN
    do_read(5'd1, 3'd0, d, v, e);
    chk("random_rst", d, 32'd15);
    repeat (14) tick();
    do_read(5'd1, 3'd0, d, v, e);
    chk("random_15", d, 32'd0);
    do_read(5'd1, 3'd0, d, v, e);
    chk("random_16", d, 32'd15);
`else
    do_read(5'd1, 3'd0, d, v, e);
    chk("random_unmap_err", 32'(e), 32'd1);
    chk("random_unmap_dat", d, 32'd0);
`endif

    do_read(5'd12, 3'd0, d, v, e);
    chk("status_rd_valid", 32'(v), 32'd1);
    chk("status_rd_data",  d,      32'h0040_0000);
    chk("status_rd_err",   32'(e), 32'd0);
    tick();
    chk("rd_valid_pulse",  32'(rd_valid), 32'd0);

    do_read(5'd20, 3'd0, d, v, e);
    chk("unmap_data", d, 32'd0);
    chk("unmap_err",  32'(e), 32'd1);
    do_read(5'd12, 3'd1, d, v, e);
    chk("badsel_err", 32'(e), 32'd1);

    do_read(5'd15, 3'd0, d, v, e);
    chk("prid", d, 32'h0001_8000);
    do_read(5'd16, 3'd0, d, v, e);
    chk("config", d, 32'h8000_0000);

    do_write(5'd12, 3'd0, 32'hFFFF_FFFF);
    do_read(5'd12, 3'd0, d, v, e);
    chk("status_mask", d, 32'h0040_FF03);
    do_write(5'd13, 3'd0, 32'hFFFF_FFFF);
    chk("cause_mask", cause_out, 32'h0000_0300);
    do_write(5'd15, 3'd0, 32'h1234_5678);
    do_read(5'd15, 3'd0, d, v, e);
    chk("prid_ro", d, 32'h0001_8000);

    // Read and write of EPC in the same cycle: read sees the old value.
    rd = 5'd14; sel = 3'd0; rd_en = 1'b1; wr_en = 1'b1; wr_data = 32'h0000_1234;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    chk("rw_same_old", rd_data, 32'h0);
    chk("rw_same_epc", epc_out, 32'h0000_1234);

    // Timer: Compare=5, Count=0, COUNT_DIV=2 -> TI after exactly 10 cycles.
    do_write(5'd11, 3'd0, 32'd5);
    do_write(5'd9,  3'd0, 32'd0);
    repeat (9) tick();
    chk("ti_early", 32'(cause_out[30]), 32'd0);
    tick();
    chk("ti_set",  32'(cause_out[30]), 32'd1);
    chk("ip7_set", 32'(cause_out[15]), 32'd1);
    do_write(5'd12, 3'd0, 32'h0000_8001);
    chk("int_pending_on", 32'(int_pending), 32'd1);
    do_write(5'd11, 3'd0, 32'd5);
    chk("ti_clear",        32'(cause_out[30]), 32'd0);
    chk("int_pending_off", 32'(int_pending), 32'd0);

    // Exception in a delay slot.
    exc_req = 1'b1; exc_code = 5'd12; exc_pc = 32'h8000_0104; exc_bd = 1'b1;
    exc_badv_vld = 1'b1; exc_badvaddr = 32'hDEAD_BEEF;
    tick();
    exc_req = 1'b0; exc_badv_vld = 1'b0;
    chk("exc_epc",  epc_out, 32'h8000_0100);
    chk("exc_bd",   32'(cause_out[31]), 32'd1);
    chk("exc_exl",  32'(status_out[1]), 32'd1);
    chk("exc_code", 32'(cause_out[6:2]), 32'd12);
    do_read(5'd8, 3'd0, d, v, e);
    chk("badvaddr", d, 32'hDEAD_BEEF);

    exc_req = 1'b1; exc_code = 5'd4; exc_pc = 32'h8000_0200; exc_bd = 1'b0;
    tick();
    exc_req = 1'b0;
    chk("exc2_epc_held", epc_out, 32'h8000_0100);
    chk("exc2_bd_held",  32'(cause_out[31]), 32'd1);
    chk("exc2_code",     32'(cause_out[6:2]), 32'd4);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("eret_exl", 32'(status_out[1]), 32'd0);

    // exc_req beats a same-cycle EPC write.
    rd = 5'd14; sel = 3'd0; wr_en = 1'b1; wr_data = 32'h5555_5555;
    exc_req = 1'b1; exc_code = 5'd8; exc_pc = 32'h8000_0300; exc_bd = 1'b0;
    tick();
    exc_req = 1'b0; wr_en = 1'b0;
    chk("exc_vs_wr_epc", epc_out, 32'h8000_0300);
    chk("exc_vs_wr_bd",  32'(cause_out[31]), 32'd0);
    // eret beats a same-cycle EPC write.
    wr_en = 1'b1; wr_data = 32'h1111_1111; eret = 1'b1;
    tick();
    wr_en = 1'b0; eret = 1'b0;
    chk("eret_vs_wr_epc", epc_out, 32'h8000_0300);
    chk("eret_vs_wr_exl", 32'(status_out[1]), 32'd0);

    // Count write on a divider-wrap cycle keeps the written value.
    do_write(5'd9, 3'd0, 32'd100);
    do_write(5'd9, 3'd0, 32'd200);
    do_read(5'd9, 3'd0, d, v, e);
    chk("count_wr_wins", d, 32'd200);

    // Hardware interrupt line sampled into IP2.
    irq_hw = 6'b000001;
    tick();
    chk("irq_hw_ip2", 32'(cause_out[15:10]), 32'h1);
    irq_hw = 6'b000000;

    // Reset while a read response is outstanding.
    rd = 5'd12; sel = 3'd0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_abort_valid",  32'(rd_valid), 32'd0);
    chk("rst_abort_status", status_out, 32'h0040_0000);
    chk("rst_abort_epc",    epc_out, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
